// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the fetch / load-store port arbiter and its RAM.
// The owner encoding tags which port an outstanding read belongs to.
package mem_port_arbiter_pkg;

  localparam int MP_ADDR_W = 5;
  localparam int MP_DATA_W = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_starve_ctr.sv
// Saturating count of cycles the fetch port has lost arbitration.
// When the count reaches MAX_WAIT, fetch takes priority over the data port.
module mem_port_starve_ctr #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_if_prio
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_if_gnt) begin
      r_wait_cnt <= '0;
    end else if (i_if_req && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_if_prio = (r_wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch (read-only) and load/store.
// Read data is bypassed from the RAM on the rvalid cycle and captured for holding afterwards.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = MP_ADDR_W,
  parameter int DATA_W   = MP_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic              w_if_prio;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_if_rvalid;
  logic              w_d_rvalid;
  logic              r_tag_valid;
  owner_e            r_tag_owner;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  mem_port_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_if_req  (if_req),
    .i_if_gnt  (w_if_gnt),
    .o_if_prio (w_if_prio)
  );

  // Data port wins contention unless fetch has been starved long enough.
  assign w_if_gnt = rst_n && if_req && (!d_req || w_if_prio);
  assign w_d_gnt  = rst_n && d_req && !w_if_gnt;

  assign if_gnt         = w_if_gnt;
  assign d_gnt          = w_d_gnt;
  assign mem_address    = w_d_gnt ? d_addr : if_addr;
  assign mem_write      = w_d_gnt && d_we;
  assign mem_write_data = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid <= 1'b0;
      r_tag_owner <= OWN_IF;
    end else begin
      r_tag_valid <= w_if_gnt || (w_d_gnt && !d_we);
      r_tag_owner <= w_d_gnt ? OWN_D : OWN_IF;
    end
  end

  assign w_if_rvalid = r_tag_valid && (r_tag_owner == OWN_IF);
  assign w_d_rvalid  = r_tag_valid && (r_tag_owner == OWN_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_rvalid) r_if_rdata <= mem_read_data;
      if (w_d_rvalid)  r_d_rdata  <= mem_read_data;
    end
  end

  assign if_rvalid = w_if_rvalid;
  assign d_rvalid  = w_d_rvalid;
  assign if_rdata  = w_if_rvalid ? mem_read_data : r_if_rdata;
  assign d_rdata   = w_d_rvalid  ? mem_read_data : r_d_rdata;

endmodule
